// File: rtl/arq_pkg.sv
// Shared types and helpers for the stop-and-wait ARQ link (transmitter and receiver sides).
package arq_pkg;

  localparam int ARQ_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    V_ACK       = 2'd0,
    V_NACK_PAR  = 2'd1,
    V_ACK_DUP   = 2'd2,
    V_NACK_FULL = 2'd3
  } verdict_t;

  // Even-parity bit over {seq, data}: makes the total number of ones even.
  function automatic logic even_par(input logic seq, input logic [ARQ_DATA_W-1:0] data);
    return ^{seq, data};
  endfunction

endpackage

// File: rtl/arq_rx_fsm_if.sv
// Frame, response, payload-stream and debug-counter signals between the ARQ receiver and its peers.
interface arq_rx_fsm_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
);
  logic              frame_valid;
  logic [DATA_W-1:0] frame_data;
  logic              frame_seq;
  logic              frame_par;
  logic              frame_ready;
  logic              ack;
  logic              nack;
  logic              ack_seq;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  dup_cnt;

  modport master (
    output frame_valid, frame_data, frame_seq, frame_par, out_ready,
    input  frame_ready, ack, nack, ack_seq, out_valid, out_data, err_cnt, dup_cnt
  );

  modport slave (
    input  frame_valid, frame_data, frame_seq, frame_par, out_ready,
    output frame_ready, ack, nack, ack_seq, out_valid, out_data, err_cnt, dup_cnt
  );
endinterface

// File: rtl/arq_rx_fifo.sv
// Circular payload FIFO with wrap-around pointers, occupancy count and zero-latency head.
module arq_rx_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_W-1:0]          head_data
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  assign full_s  = (count_r == (AW+1)'(DEPTH));
  assign empty_s = (count_r == (AW+1)'(0));
  assign push_s  = push && !full_s;
  assign pop_s   = pop && !empty_s;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign empty     = empty_s;
  assign count     = count_r;
  assign head_data = empty_s ? '0 : mem_r[rd_ptr_r];

endmodule

// File: rtl/arq_rx_fsm.sv
// Stop-and-wait ARQ receiver: checks parity and sequence of each frame, answers with one ACK/NACK
// pulse, buffers accepted payloads and keeps saturating debug counters.
module arq_rx_fsm
  import arq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  arq_rx_fsm_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  state_t              state_r;
  verdict_t            verdict_r;
  verdict_t            verdict_s;
  logic [DATA_W-1:0]   data_r;
  logic                seq_r;
  logic                par_r;
  logic                exp_seq_r;
  logic [CNT_W-1:0]    err_cnt_r;
  logic [CNT_W-1:0]    dup_cnt_r;
  logic                ack_r;
  logic                nack_r;
  logic                ack_seq_r;
  logic                frame_ready_r;
  logic                push_s;
  logic                full_s;
  logic                fifo_empty_s;
  logic [AW:0]         fifo_count_s;
  logic [DATA_W-1:0]   fifo_head_s;

  // The full test sees this cycle's occupancy, so a concurrent pop cannot rescue the frame.
  assign full_s = (fifo_count_s == (AW+1)'(DEPTH));
  assign push_s = (state_r == RESP) && (verdict_r == V_ACK);

  // Verdict priority: corrupt frame, then duplicate (lost ACK), then back-pressure.
  always_comb begin
    verdict_s = V_ACK;
    if (par_r != even_par(seq_r, data_r)) begin
      verdict_s = V_NACK_PAR;
    end else if (seq_r != exp_seq_r) begin
      verdict_s = V_ACK_DUP;
    end else if (full_s) begin
      verdict_s = V_NACK_FULL;
    end else begin
      verdict_s = V_ACK;
    end
  end

  // Frame FSM with registered handshake outputs and side effects committed in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      verdict_r     <= V_ACK;
      data_r        <= '0;
      seq_r         <= 1'b0;
      par_r         <= 1'b0;
      exp_seq_r     <= 1'b0;
      err_cnt_r     <= '0;
      dup_cnt_r     <= '0;
      ack_r         <= 1'b0;
      nack_r        <= 1'b0;
      ack_seq_r     <= 1'b0;
      frame_ready_r <= 1'b1;
    end else begin
      ack_r     <= 1'b0;
      nack_r    <= 1'b0;
      ack_seq_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.frame_valid) begin
            data_r        <= bus.frame_data;
            seq_r         <= bus.frame_seq;
            par_r         <= bus.frame_par;
            state_r       <= CHECK;
            frame_ready_r <= 1'b0;
          end else begin
            state_r       <= IDLE;
            frame_ready_r <= 1'b1;
          end
        end
        CHECK: begin
          verdict_r <= verdict_s;
          ack_r     <= (verdict_s == V_ACK) || (verdict_s == V_ACK_DUP);
          nack_r    <= (verdict_s == V_NACK_PAR) || (verdict_s == V_NACK_FULL);
          ack_seq_r <= seq_r;
          state_r   <= RESP;
        end
        RESP: begin
          case (verdict_r)
            V_NACK_PAR: begin
              if (err_cnt_r != {CNT_W{1'b1}}) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
              end
            end
            V_ACK_DUP: begin
              if (dup_cnt_r != {CNT_W{1'b1}}) begin
                dup_cnt_r <= dup_cnt_r + CNT_W'(1);
              end
            end
            V_ACK:       exp_seq_r <= ~exp_seq_r;
            default:     exp_seq_r <= exp_seq_r;
          endcase
          state_r       <= IDLE;
          frame_ready_r <= 1'b1;
        end
        default: begin
          state_r       <= IDLE;
          frame_ready_r <= 1'b1;
        end
      endcase
    end
  end

  arq_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (data_r),
    .pop       (bus.out_ready),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .head_data (fifo_head_s)
  );

  assign bus.frame_ready = frame_ready_r;
  assign bus.ack         = ack_r;
  assign bus.nack        = nack_r;
  assign bus.ack_seq     = ack_seq_r;
  assign bus.out_valid   = !fifo_empty_s;
  assign bus.out_data    = fifo_head_s;
  assign bus.err_cnt     = err_cnt_r;
  assign bus.dup_cnt     = dup_cnt_r;

endmodule

// File: tb/tb_arq_rx_fsm.sv
// Directed bench for arq_rx_fsm: a vector table of frames with hand-computed responses plus
// hand-written sequences for cadence, drain order, mid-frame reset and counter saturation.
module tb_arq_rx_fsm;

  typedef struct {
    logic       seq;
    logic [3:0] data;
    logic       flip;
    logic       rdy_chk;
    logic       rdy_rsp;
    logic       e_ack;
    logic       e_nack;
    logic [3:0] e_err;
    logic [3:0] e_dup;
    logic       e_ov;
    logic [3:0] e_head;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [3:0] popped_q[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  arq_rx_fsm_if #(.DATA_W(4), .CNT_W(4)) bus_if();

  arq_rx_fsm #(.DATA_W(4), .DEPTH(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Record every payload the consumer actually pops (sampled mid-cycle, before the pop edge).
  always @(negedge clk) begin
    #1;
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      popped_q.push_back(bus_if.out_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one frame at a negedge in IDLE and check the 3-cycle response.
  task automatic send(input vec_t v, input string tag);
    chk({tag, "_rdy_idle"}, bus_if.frame_ready, 1);
    bus_if.frame_valid = 1'b1;
    bus_if.frame_seq   = v.seq;
    bus_if.frame_data  = v.data;
    bus_if.frame_par   = (^{v.seq, v.data}) ^ v.flip;
    @(negedge clk);
    bus_if.frame_valid = 1'b0;
    bus_if.out_ready   = v.rdy_chk;
    chk({tag, "_early"}, {bus_if.ack, bus_if.nack}, 0);
    chk({tag, "_rdy_busy"}, bus_if.frame_ready, 0);
    @(negedge clk);
    bus_if.out_ready = v.rdy_rsp;
    chk({tag, "_ack"}, bus_if.ack, v.e_ack);
    chk({tag, "_nack"}, bus_if.nack, v.e_nack);
    chk({tag, "_ack_seq"}, bus_if.ack_seq, v.seq);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {bus_if.ack, bus_if.nack}, 0);
    chk({tag, "_err"}, bus_if.err_cnt, v.e_err);
    chk({tag, "_dup"}, bus_if.dup_cnt, v.e_dup);
    chk({tag, "_ov"}, bus_if.out_valid, v.e_ov);
    if (v.e_ov) begin
      chk({tag, "_head"}, bus_if.out_data, v.e_head);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ack"}, bus_if.ack, 0);
    chk({tag, "_nack"}, bus_if.nack, 0);
    chk({tag, "_ack_seq"}, bus_if.ack_seq, 0);
    chk({tag, "_ov"}, bus_if.out_valid, 0);
    chk({tag, "_od"}, bus_if.out_data, 0);
    chk({tag, "_err"}, bus_if.err_cnt, 0);
    chk({tag, "_dup"}, bus_if.dup_cnt, 0);
    chk({tag, "_fr"}, bus_if.frame_ready, 1);
  endtask

  initial begin
    logic [3:0] exp_pop[8];
    int         pos[$];
    int         pulses;
    vec_t       v;

    //            seq   data  flip  rchk  rrsp  ack   nack  err   dup   ov    head
    vecs[0]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 4'h0};
    vecs[1]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 4'h0};
    vecs[2]  = '{1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 4'h0};
    vecs[3]  = '{1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 4'h0};
    vecs[4]  = '{1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 4'h0};
    vecs[5]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 4'h0};
    vecs[6]  = '{1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1, 4'h0};
    vecs[7]  = '{1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 1'b1, 4'h0};
    vecs[8]  = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 1'b1, 4'h0};
    vecs[9]  = '{1'b0, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 4'h3};
    vecs[10] = '{1'b0, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd2, 1'b1, 4'h6};
    vecs[11] = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 1'b1, 4'h9};
    vecs[12] = '{1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd2, 1'b1, 4'hC};
    exp_pop = '{4'h0, 4'hA, 4'h3, 4'h5, 4'h6, 4'h9, 4'hC, 4'h1};

    bus_if.frame_valid = 1'b0;
    bus_if.frame_data  = 4'h0;
    bus_if.frame_seq   = 1'b0;
    bus_if.frame_par   = 1'b0;
    bus_if.out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      send(vecs[i], $sformatf("v%0d", i));
    end

    // Frame held valid continuously: one pulse every 3 cycles (first accepted, then re-ACKs).
    bus_if.frame_valid = 1'b1;
    bus_if.frame_seq   = 1'b1;
    bus_if.frame_data  = 4'h1;
    bus_if.frame_par   = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus_if.ack || bus_if.nack) pos.push_back(c);
      if (bus_if.nack) pulses++;
    end
    bus_if.frame_valid = 1'b0;
    chk("cad_count", pos.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cad_pos%0d", i), (pos.size() > i) ? pos[i] : -1, 2 + 3 * i);
    end
    chk("cad_no_nack", pulses, 0);
    chk("cad_dup", bus_if.dup_cnt, 4);
    chk("cad_err", bus_if.err_cnt, 2);

    for (int w = 0; w < 20 && bus_if.out_valid; w++) @(negedge clk);
    chk("drain_empty", bus_if.out_valid, 0);
    chk("drain_len", popped_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), (popped_q.size() > i) ? popped_q[i] : 4'hx, exp_pop[i]);
    end

    // Reset while the frame sits in CHECK: no response, everything back to reset values.
    bus_if.out_ready   = 1'b0;
    bus_if.frame_valid = 1'b1;
    bus_if.frame_seq   = 1'b0;
    bus_if.frame_data  = 4'hF;
    bus_if.frame_par   = ^{1'b0, 4'hF};
    @(negedge clk);
    bus_if.frame_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("mid_rst");
    rst_n = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.ack || bus_if.nack) pulses++;
    end
    chk("mid_rst_silent", pulses, 0);

    // exp_seq is back to 0, so seq=1 must be treated as a duplicate.
    v = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 4'h0};
    send(v, "post_rst_dup");

    for (int i = 0; i < 17; i++) begin
      v = '{1'b0, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
            (i >= 14) ? 4'd15 : 4'(i + 1), 4'd1, 1'b0, 4'h0};
      send(v, $sformatf("sat%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
